conv3x3_pool_stream: RTL and testbench

- Streaming 3x3 convolution engine with an optional 2x2/stride-2 max-pool stage. It replaces the store-then-compute convolution block in the IFM→OFM datapath.
- Pixels arrive in raster order and go through two line buffers and a 3x3 window register, so no full-frame IFM storage is needed.
- Width, frame size and pool mode are parametrised. Input stalls (gaps in in_valid) and back-to-back frames are supported.

---
 rtl/conv_pkg.sv | 20 ++
 rtl/line_buffer_shift.sv | 27 ++
 rtl/conv3x3_pool_stream.sv | 201 ++++++++++++++++++++
 tb/tb_conv3x3_pool_stream.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming 3x3 convolution / max-pool engine.
package conv_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_IMG_W  = 14;
  localparam int DEF_IMG_H  = 14;

  typedef enum logic {IDLE, RUN} state_t;

  // Nine full-width products need four extra bits of headroom.
  function automatic int acc_w(input int data_w);
    return 2 * data_w + 4;
  endfunction

  // Unsigned maximum; callers zero-extend into and truncate out of 64 bits.
  function automatic logic [63:0] max2(input logic [63:0] a, input logic [63:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/line_buffer_shift.sv
// DEPTH x WIDTH shift register holding one image row minus the window column.
module line_buffer_shift #(
  parameter int DEPTH = 13,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  // Shift one position per accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (en) begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/conv3x3_pool_stream.sv
// Streaming 3x3 convolution with optional 2x2/stride-2 max-pool.
//   state | meaning
//   IDLE  | waiting for beat 0 of a frame (pixel (0,0), weight k0)
//   RUN   | frame in progress; returns to IDLE after the last pixel
// The conv sum is formed combinationally on the accepting beat from the two
// stored window columns, the two line-buffer taps and the incoming pixel.
module conv3x3_pool_stream
  import conv_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int POOL_EN = 1,
  localparam int ACC_W  = acc_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] In_IFM,
  input  logic [DATA_W-1:0] In_Weight,
  output logic              out_valid,
  output logic [ACC_W-1:0]  Out_OFM,
  output logic              frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PN = (IMG_W - 2) / 2;
  localparam int PW = (PN > 1) ? $clog2(PN) : 1;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic [3:0]        beat_q;
  logic              last_px, conv_en;
  logic [DATA_W-1:0] w_ld [9];
  logic [DATA_W-1:0] w_act [9];
  logic [DATA_W-1:0] win_top [2];
  logic [DATA_W-1:0] win_mid [2];
  logic [DATA_W-1:0] win_bot [2];
  logic [DATA_W-1:0] lb0_out, lb1_out;
  logic [DATA_W-1:0] px [9];
  logic [ACC_W-1:0]  conv_sum;
  logic              conv_v_q, r_odd_q, c_odd_q, last_q;
  logic [PW-1:0]     j_q;
  logic [ACC_W-1:0]  conv_q, even_q, pair_max, pool_max;
  logic [ACC_W-1:0]  pool_buf [PN];

  assign last_px = in_valid && (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
  assign conv_en = in_valid && (row_q >= RW'(2)) && (col_q >= CW'(2));

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: start on any accepted beat, finish on the last pixel.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_px)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Raster position and weight-load beat counter; all hold during stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= '0;
      col_q  <= '0;
      beat_q <= '0;
    end else if (in_valid) begin
      if (last_px) begin
        row_q  <= '0;
        col_q  <= '0;
        beat_q <= '0;
      end else begin
        if (col_q == CW'(IMG_W - 1)) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
        if (beat_q != 4'd9) beat_q <= beat_q + 4'd1;
      end
    end
  end

  // Weights land in a load set on beats 0..8 and move to the active set one
  // beat before the first result, so the previous frame is never disturbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        w_ld[i]  <= '0;
        w_act[i] <= '0;
      end
    end else if (in_valid) begin
      if (beat_q < 4'd9) w_ld[beat_q] <= In_Weight;
      if (row_q == RW'(2) && col_q == CW'(1)) begin
        for (int i = 0; i < 9; i++) w_act[i] <= w_ld[i];
      end
    end
  end

  line_buffer_shift #(.DEPTH(IMG_W - 1), .WIDTH(DATA_W)) u_lb0 (
    .clk(clk), .rst_n(rst_n), .en(in_valid), .din(win_bot[1]), .dout(lb0_out)
  );

  line_buffer_shift #(.DEPTH(IMG_W - 1), .WIDTH(DATA_W)) u_lb1 (
    .clk(clk), .rst_n(rst_n), .en(in_valid), .din(win_mid[1]), .dout(lb1_out)
  );

  // Window columns: [1] is the newest stored column, [0] the one before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        win_top[i] <= '0;
        win_mid[i] <= '0;
        win_bot[i] <= '0;
      end
    end else if (in_valid) begin
      win_top[0] <= win_top[1];
      win_mid[0] <= win_mid[1];
      win_bot[0] <= win_bot[1];
      win_top[1] <= lb1_out;
      win_mid[1] <= lb0_out;
      win_bot[1] <= In_IFM;
    end
  end

  // 3x3 multiply-accumulate over the window including the incoming column.
  always_comb begin
    px[0] = win_top[0];
    px[1] = win_top[1];
    px[2] = lb1_out;
    px[3] = win_mid[0];
    px[4] = win_mid[1];
    px[5] = lb0_out;
    px[6] = win_bot[0];
    px[7] = win_bot[1];
    px[8] = In_IFM;
    conv_sum = '0;
    for (int i = 0; i < 9; i++) conv_sum = conv_sum + ACC_W'(w_act[i]) * ACC_W'(px[i]);
  end

  // Conv result register feeding the pool stage, tagged with its position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_v_q <= 1'b0;
      conv_q   <= '0;
      r_odd_q  <= 1'b0;
      c_odd_q  <= 1'b0;
      last_q   <= 1'b0;
      j_q      <= '0;
    end else begin
      conv_v_q <= conv_en;
      if (conv_en) begin
        conv_q  <= conv_sum;
        r_odd_q <= row_q[0];
        c_odd_q <= col_q[0];
        last_q  <= last_px;
        j_q     <= PW'((col_q - CW'(2)) >> 1);
      end
    end
  end

  assign pair_max = ACC_W'(max2(64'(even_q), 64'(conv_q)));
  assign pool_max = ACC_W'(max2(64'(pair_max), 64'(pool_buf[j_q])));

  // Output stage: raw conv map one cycle after the pixel, or the pooled max
  // once the odd-row/odd-column member of each 2x2 block arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      Out_OFM    <= '0;
      even_q     <= '0;
      for (int i = 0; i < PN; i++) pool_buf[i] <= '0;
    end else if (POOL_EN == 0) begin
      out_valid  <= conv_en;
      frame_done <= conv_en && last_px;
      if (conv_en) Out_OFM <= conv_sum;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (conv_v_q && !c_odd_q) even_q <= conv_q;
      if (conv_v_q && c_odd_q) begin
        if (!r_odd_q) begin
          pool_buf[j_q] <= pair_max;
        end else begin
          Out_OFM    <= pool_max;
          out_valid  <= 1'b1;
          frame_done <= last_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_pool_stream.sv
// Directed bench: one pooled and one raw instance share the same stimulus.
module tb_conv3x3_pool_stream;

  localparam int IMG_W = 14;
  localparam int IMG_H = 14;
  localparam int NP = ((IMG_H - 2) / 2) * ((IMG_W - 2) / 2);
  localparam int NR = (IMG_H - 2) * (IMG_W - 2);

  typedef struct {
    int          pm;
    int          wm;
    int          gap;
    logic [35:0] pf, pl, rf, rl;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_ifm = '0;
  logic [15:0] in_weight = '0;
  logic        ov_p, fd_p, ov_r, fd_r;
  logic [35:0] out_p, out_r;

  int checks = 0;
  int failures = 0;
  int cur_r = 0;
  int cur_c = 0;
  logic [35:0] q_p[$];
  logic [35:0] q_r[$];
  int fdpos_p[$];
  int fdpos_r[$];
  logic hist_r = 1'b0, hist_p1 = 1'b0, hist_p2 = 1'b0;
  vec_t vecs[4];

  always #5 clk = ~clk;

  conv3x3_pool_stream #(.DATA_W(16), .IMG_W(IMG_W), .IMG_H(IMG_H), .POOL_EN(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .In_IFM(in_ifm), .In_Weight(in_weight),
    .out_valid(ov_p), .Out_OFM(out_p), .frame_done(fd_p)
  );

  conv3x3_pool_stream #(.DATA_W(16), .IMG_W(IMG_W), .IMG_H(IMG_H), .POOL_EN(0)) dut_r (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .In_IFM(in_ifm), .In_Weight(in_weight),
    .out_valid(ov_r), .Out_OFM(out_r), .frame_done(fd_r)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function automatic logic [15:0] pix(int pm, int r, int c);
    if (pm == 0) return 16'd1;
    if (pm == 1) return 16'(IMG_W * r + c);
    return 16'hFFFF;
  endfunction

  function automatic logic [15:0] wt(int wm, int k);
    if (wm == 0) return 16'd1;
    if (wm == 1) return (k == 4) ? 16'd1 : 16'd0;
    return 16'hFFFF;
  endfunction

  function automatic logic [35:0] conv_m(int pm, int wm, int cr, int cc);
    logic [35:0] s = '0;
    for (int k = 0; k < 9; k++) s = s + 36'(wt(wm, k)) * 36'(pix(pm, cr + k / 3, cc + k % 3));
    return s;
  endfunction

  function automatic logic [35:0] pool_m(int pm, int wm, int pi, int pj);
    logic [35:0] m = '0;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        if (conv_m(pm, wm, 2 * pi + a, 2 * pj + b) > m) m = conv_m(pm, wm, 2 * pi + a, 2 * pj + b);
    return m;
  endfunction

  // Capture outputs and compare output timing against the accepted-pixel history.
  always @(negedge clk) begin
    if (ov_p) q_p.push_back(out_p);
    if (ov_r) q_r.push_back(out_r);
    if (fd_p) fdpos_p.push_back(ov_p ? q_p.size() : -1);
    if (fd_r) fdpos_r.push_back(ov_r ? q_r.size() : -1);
    if (!rst_n) begin
      hist_r = 1'b0; hist_p1 = 1'b0; hist_p2 = 1'b0;
    end else begin
      chk("raw_out_valid_timing", 64'(ov_r), 64'(hist_r));
      chk("pool_out_valid_timing", 64'(ov_p), 64'(hist_p2));
      hist_p2 = hist_p1;
      hist_r  = in_valid && cur_r >= 2 && cur_c >= 2;
      hist_p1 = in_valid && cur_r >= 3 && cur_c >= 3 && (cur_r % 2 == 1) && (cur_c % 2 == 1);
    end
  end

  task automatic run_frame(int pm, int wm, int gap, int abort_at);
    for (int b = 0; b < IMG_W * IMG_H; b++) begin
      if (b == abort_at) begin
        in_valid = 1'b0;
        return;
      end
      while (gap > 0 && $urandom_range(99) < gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid  = 1'b1;
      cur_r     = b / IMG_W;
      cur_c     = b % IMG_W;
      in_ifm    = pix(pm, cur_r, cur_c);
      in_weight = (b < 9) ? wt(wm, b) : 16'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic clear_q();
    q_p.delete(); q_r.delete(); fdpos_p.delete(); fdpos_r.delete();
  endtask

  task automatic check_seg(int f, int pm, int wm);
    for (int i = 0; i < NP; i++) begin
      logic [35:0] a = (f * NP + i < q_p.size()) ? q_p[f * NP + i] : '1;
      chk("pool_value", 64'(a), 64'(pool_m(pm, wm, i / 6, i % 6)));
    end
    for (int i = 0; i < NR; i++) begin
      logic [35:0] a = (f * NR + i < q_r.size()) ? q_r[f * NR + i] : '1;
      chk("raw_value", 64'(a), 64'(conv_m(pm, wm, i / 12, i % 12)));
    end
  endtask

  task automatic check_counts(int nfr);
    chk("pool_count", 64'(q_p.size()), 64'(nfr * NP));
    chk("raw_count", 64'(q_r.size()), 64'(nfr * NR));
    chk("pool_frame_done_count", 64'(fdpos_p.size()), 64'(nfr));
    chk("raw_frame_done_count", 64'(fdpos_r.size()), 64'(nfr));
    for (int k = 0; k < fdpos_p.size(); k++) chk("pool_frame_done_pos", 64'(fdpos_p[k]), 64'((k + 1) * NP));
    for (int k = 0; k < fdpos_r.size(); k++) chk("raw_frame_done_pos", 64'(fdpos_r[k]), 64'((k + 1) * NR));
  endtask

  initial begin
    vecs[0] = '{pm: 0, wm: 0, gap: 0,  pf: 36'd9,  pl: 36'd9,   rf: 36'd9,  rl: 36'd9};
    vecs[1] = '{pm: 1, wm: 1, gap: 0,  pf: 36'd30, pl: 36'd180, rf: 36'd15, rl: 36'd180};
    vecs[2] = '{pm: 2, wm: 2, gap: 0,  pf: 36'd38653526025, pl: 36'd38653526025,
                rf: 36'd38653526025, rl: 36'd38653526025};
    vecs[3] = '{pm: 1, wm: 1, gap: 30, pf: 36'd30, pl: 36'd180, rf: 36'd15, rl: 36'd180};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid_pool", 64'(ov_p), 64'(0));
    chk("reset_out_ofm_pool", 64'(out_p), 64'(0));
    chk("reset_frame_done_pool", 64'(fd_p), 64'(0));
    chk("reset_out_valid_raw", 64'(ov_r), 64'(0));
    chk("reset_out_ofm_raw", 64'(out_r), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      clear_q();
      run_frame(vecs[v].pm, vecs[v].wm, vecs[v].gap, -1);
      repeat (8) @(posedge clk);
      #1;
      check_counts(1);
      if (q_p.size() == NP) begin
        chk("pool_first", 64'(q_p[0]), 64'(vecs[v].pf));
        chk("pool_last", 64'(q_p[NP - 1]), 64'(vecs[v].pl));
      end
      if (q_r.size() == NR) begin
        chk("raw_first", 64'(q_r[0]), 64'(vecs[v].rf));
        chk("raw_last", 64'(q_r[NR - 1]), 64'(vecs[v].rl));
      end
      check_seg(0, vecs[v].pm, vecs[v].wm);
    end

    // Back-to-back frames with different weights: old frame drains intact.
    clear_q();
    run_frame(1, 1, 0, -1);
    run_frame(0, 0, 0, -1);
    repeat (8) @(posedge clk);
    #1;
    check_counts(2);
    check_seg(0, 1, 1);
    check_seg(1, 0, 0);

    // Reset in the middle of a frame, then a clean all-ones frame.
    clear_q();
    run_frame(1, 1, 0, 100);
    rst_n = 1'b0;
    #2;
    chk("midreset_out_valid_pool", 64'(ov_p), 64'(0));
    chk("midreset_out_ofm_pool", 64'(out_p), 64'(0));
    chk("midreset_out_valid_raw", 64'(ov_r), 64'(0));
    chk("midreset_out_ofm_raw", 64'(out_r), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("midreset_hold_out_ofm_pool", 64'(out_p), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_q();
    run_frame(0, 0, 0, -1);
    repeat (8) @(posedge clk);
    #1;
    check_counts(1);
    check_seg(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
